// File: rtl/gba_i2s_out.sv
`default_nettype none
// ============================================================================
//  Module      : gba_i2s_out
//  Description : GBA audio output stage. Issues a once-per-frame new_sample
//                request, double-buffers the stereo answer from the mixer and
//                serialises it as standard I2S (BCLK = 64*fs, LRCLK, SDATA).
//                Flags a sticky underrun when a frame starts without a fresh
//                sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module gba_i2s_out #(
    parameter int CLK_DIV     = 16,
    parameter int SAMPLE_BITS = 24
) (
    input  logic                   clk_100,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [SAMPLE_BITS-1:0] sample_l,
    input  logic [SAMPLE_BITS-1:0] sample_r,
    input  logic                   sample_valid,
    input  logic                   underrun_clr,
    output logic                   new_sample,
    output logic                   i2s_bclk,
    output logic                   i2s_lrclk,
    output logic                   i2s_sdata,
    output logic                   underrun
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       BIT_PARK = 6'd63;

    logic [DIV_W-1:0]       div_cnt;
    logic [5:0]             bit_cnt;
    logic [SAMPLE_BITS-1:0] hold_l;
    logic [SAMPLE_BITS-1:0] hold_r;
    logic [SAMPLE_BITS-1:0] frame_l;
    logic [SAMPLE_BITS-1:0] frame_r;
    logic                   fresh;

    logic                   tick;
    logic                   fall;
    logic                   frame_start;
    logic [5:0]             next_bit;
    logic [SAMPLE_BITS-1:0] word;
    logic [31:0]            slot;
    logic                   next_sdata;

    // BCLK half-period boundary; a boundary while BCLK is high is a falling edge.
    assign tick        = enable && (div_cnt == DIV_LAST);
    assign fall        = tick && i2s_bclk;
    assign next_bit    = bit_cnt + 6'd1;
    assign frame_start = fall && (next_bit == 6'd0);

    // Slot image: bit 31 is the one-BCLK I2S delay bit, the word follows MSB
    // first and the remainder is zero padding, so slot position b maps to
    // slot[31-b] (which is ~b for a 5-bit b).
    assign word       = next_bit[5] ? frame_r : frame_l;
    assign slot       = 32'({1'b0, word}) << (31 - SAMPLE_BITS);
    assign next_sdata = slot[~next_bit[4:0]];

    // Clock divider, bit clock, bit position and serial outputs; parked while disabled.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= BIT_PARK;
            i2s_bclk   <= 1'b0;
            i2s_lrclk  <= 1'b0;
            i2s_sdata  <= 1'b0;
            new_sample <= 1'b0;
        end else if (!enable) begin
            div_cnt    <= '0;
            bit_cnt    <= BIT_PARK;
            i2s_bclk   <= 1'b0;
            i2s_lrclk  <= 1'b0;
            i2s_sdata  <= 1'b0;
            new_sample <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            new_sample <= frame_start;
            if (tick) begin
                i2s_bclk <= ~i2s_bclk;
            end
            if (fall) begin
                bit_cnt   <= next_bit;
                i2s_lrclk <= next_bit[5];
                i2s_sdata <= next_sdata;
            end
        end
    end

    // Sample double buffer: hold captures the mixer answer, frame is latched at frame start.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            hold_l  <= '0;
            hold_r  <= '0;
            frame_l <= '0;
            frame_r <= '0;
            fresh   <= 1'b0;
        end else begin
            if (sample_valid) begin
                hold_l <= sample_l;
                hold_r <= sample_r;
            end
            if (frame_start) begin
                frame_l <= hold_l;
                frame_r <= hold_r;
            end
            // A valid coinciding with the frame start refills hold for the next frame.
            if (sample_valid) begin
                fresh <= 1'b1;
            end else if (frame_start) begin
                fresh <= 1'b0;
            end
        end
    end

    // Sticky underrun: set when a frame starts on stale data; set beats clear.
    always_ff @(posedge clk_100 or posedge reset) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (frame_start && !fresh) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gba_i2s_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gba_i2s_out
//  Description : Directed self-checking bench for gba_i2s_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gba_i2s_out;

    localparam logic [63:0] FRAME_ZERO = 64'h00000000_00000000;
    localparam logic [63:0] FRAME_A5   = 64'h52D2D280_2D2D2D00; // L=A5A5A5 R=5A5A5A
    localparam logic [63:0] FRAME_X1   = 64'h091A2B00_7F6E5D00; // L=123456 R=FEDCBA
    localparam logic [63:0] LR_PAT     = 64'h00000000_FFFFFFFF;

    logic        clk_100 = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        sample_valid;
    logic [23:0] sample_l;
    logic [23:0] sample_r;
    logic        new_sample;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        underrun;

    logic        man_valid = 1'b0;
    logic [23:0] man_l = 24'h0;
    logic [23:0] man_r = 24'h0;
    logic        auto_en = 1'b0;
    logic        auto_valid = 1'b0;
    logic [23:0] auto_l = 24'h0;
    logic [23:0] auto_r = 24'h0;

    int vectors = 0;
    int miscompares = 0;

    assign sample_valid = man_valid | auto_valid;
    assign sample_l     = auto_valid ? auto_l : man_l;
    assign sample_r     = auto_valid ? auto_r : man_r;

    always #5 clk_100 = ~clk_100;

    gba_i2s_out #(.CLK_DIV(16), .SAMPLE_BITS(24)) dut (
        .clk_100      (clk_100),
        .reset        (reset),
        .enable       (enable),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .underrun_clr (underrun_clr),
        .new_sample   (new_sample),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .underrun     (underrun)
    );

    // Mixer stand-in: answers a new_sample request with a one-cycle valid.
    always @(negedge clk_100) begin
        if (auto_valid) auto_valid = 1'b0;
        else if (auto_en && new_sample) auto_valid = 1'b1;
    end

    // Line monitor: rebuilds each 64-bit frame from SDATA/LRCLK at BCLK falls.
    int          cyc = 0;
    int          mon_pos = 63;
    int          frames_done = 0;
    int          ns_period = 0;
    int          ns_last = 0;
    bit          ns_seen = 1'b0;
    int          ns_run = 0;
    int          ns_width_max = 0;
    int          bclk_period = 0;
    int          last_rise = 0;
    bit          rise_seen = 1'b0;
    logic        prev_bclk = 1'b0;
    logic [63:0] fw = '0;
    logic [63:0] lw = '0;
    logic [63:0] last_lr = '0;
    logic [63:0] frame_hist [0:15];

    always @(negedge clk_100) begin
        cyc = cyc + 1;
        if (reset || !enable) begin
            mon_pos   = 63;
            prev_bclk = 1'b0;
            ns_run    = 0;
        end else begin
            if (prev_bclk && !i2s_bclk) begin
                mon_pos = (mon_pos + 1) % 64;
                fw[63 - mon_pos] = i2s_sdata;
                lw[63 - mon_pos] = i2s_lrclk;
                if (mon_pos == 63) begin
                    frames_done = frames_done + 1;
                    if (frames_done < 16) frame_hist[frames_done] = fw;
                    last_lr = lw;
                end
            end
            if (!prev_bclk && i2s_bclk) begin
                if (rise_seen) bclk_period = cyc - last_rise;
                last_rise = cyc;
                rise_seen = 1'b1;
            end
            if (new_sample) begin
                if (ns_seen) ns_period = cyc - ns_last;
                ns_last = cyc;
                ns_seen = 1'b1;
                ns_run  = ns_run + 1;
                if (ns_run > ns_width_max) ns_width_max = ns_run;
            end else begin
                ns_run = 0;
            end
            prev_bclk = i2s_bclk;
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100);
            #1;
        end
    endtask

    task automatic wait_ns(input string tag);
        for (int i = 0; i < 2200; i++) begin
            step(1);
            if (new_sample === 1'b1) return;
        end
        vectors++; miscompares++;
        $display("FAIL %s: new_sample not seen within 2200 cycles", tag);
    endtask

    task automatic wait_frames(input int k);
        for (int i = 0; i < 4400; i++) begin
            if (frames_done >= k) return;
            step(1);
        end
        vectors++; miscompares++;
        $display("FAIL wait_frames: got %0d frames, need %0d", frames_done, k);
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 2200; i++) begin
            if (mon_pos == p) return;
            step(1);
        end
        vectors++; miscompares++;
        $display("FAIL wait_pos: bit position %0d never reached, at %0d", p, mon_pos);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        auto_l = 24'hA5A5A5; auto_r = 24'h5A5A5A; auto_en = 1'b1;
        step(3);
        vectors++;
        if ({new_sample, i2s_bclk, i2s_lrclk, i2s_sdata, underrun} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {new_sample, i2s_bclk, i2s_lrclk, i2s_sdata, underrun});
        end
        reset = 1'b0;
        step(15);
        vectors++;
        if (i2s_bclk !== 1'b0) begin
            miscompares++; $display("FAIL bclk_before_rise: got %b want 0", i2s_bclk);
        end
        step(1);
        vectors++;
        if (i2s_bclk !== 1'b1) begin
            miscompares++; $display("FAIL first_rise: got %b want 1", i2s_bclk);
        end
        step(15);
        vectors++;
        if ({i2s_bclk, new_sample} !== 2'b10) begin
            miscompares++; $display("FAIL before_first_fall: bclk,ns got %b want 10", {i2s_bclk, new_sample});
        end
        step(1);
        vectors++;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, new_sample} !== 4'b0001) begin
            miscompares++;
            $display("FAIL first_fall: bclk,lr,sd,ns got %b want 0001",
                     {i2s_bclk, i2s_lrclk, i2s_sdata, new_sample});
        end
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++; $display("FAIL first_frame_underrun: got %b want 1", underrun);
        end
        step(1);
        vectors++;
        if (new_sample !== 1'b0) begin
            miscompares++; $display("FAIL ns_one_cycle: got %b want 0", new_sample);
        end
    endtask

    task automatic test_serial();
        wait_frames(2);
        vectors++;
        if (frame_hist[1] !== FRAME_ZERO) begin
            miscompares++; $display("FAIL frame1_data: got %h want %h", frame_hist[1], FRAME_ZERO);
        end
        vectors++;
        if (frame_hist[2] !== FRAME_A5) begin
            miscompares++; $display("FAIL frame2_data: got %h want %h", frame_hist[2], FRAME_A5);
        end
        vectors++;
        if (last_lr !== LR_PAT) begin
            miscompares++; $display("FAIL lrclk_pattern: got %h want %h", last_lr, LR_PAT);
        end
    endtask

    task automatic test_period();
        vectors++;
        if (ns_period !== 2048) begin
            miscompares++; $display("FAIL ns_period: got %0d want 2048", ns_period);
        end
        vectors++;
        if (bclk_period !== 32) begin
            miscompares++; $display("FAIL bclk_period: got %0d want 32", bclk_period);
        end
        vectors++;
        if (ns_width_max !== 1) begin
            miscompares++; $display("FAIL ns_width: got %0d want 1", ns_width_max);
        end
    endtask

    task automatic test_underrun();
        auto_l = 24'h123456; auto_r = 24'hFEDCBA;
        underrun_clr = 1'b1; step(1); underrun_clr = 1'b0;
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++; $display("FAIL underrun_clear1: got %b want 0", underrun);
        end
        wait_ns("frame3");
        step(3); auto_en = 1'b0;
        wait_ns("frame4");
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++; $display("FAIL frame4_no_underrun: got %b want 0", underrun);
        end
        step(3); auto_l = 24'hA5A5A5; auto_r = 24'h5A5A5A; auto_en = 1'b1;
        wait_ns("frame5");
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++; $display("FAIL skip_underrun: got %b want 1", underrun);
        end
        step(3);
        underrun_clr = 1'b1; step(1); underrun_clr = 1'b0;
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++; $display("FAIL underrun_clear2: got %b want 0", underrun);
        end
        wait_frames(5);
        vectors++;
        if (frame_hist[4] !== FRAME_X1) begin
            miscompares++; $display("FAIL frame4_data: got %h want %h", frame_hist[4], FRAME_X1);
        end
        vectors++;
        if (frame_hist[5] !== FRAME_X1) begin
            miscompares++; $display("FAIL repeat_frame5: got %h want %h", frame_hist[5], FRAME_X1);
        end
        wait_ns("frame6");
        wait_ns("frame7");
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++; $display("FAIL resupply_underrun: got %b want 0", underrun);
        end
        vectors++;
        if (frame_hist[6] !== FRAME_A5) begin
            miscompares++; $display("FAIL frame6_data: got %h want %h", frame_hist[6], FRAME_A5);
        end
        step(3); auto_en = 1'b0;
    endtask

    task automatic test_coincident();
        wait_ns("frame8");
        for (int i = 1; i <= 2047; i++) begin
            step(1);
            if (i == 10) begin
                man_l = 24'hA5A5A5; man_r = 24'h5A5A5A; man_valid = 1'b1;
            end else if (i == 11) begin
                man_valid = 1'b0;
            end else if (i == 2047) begin
                man_l = 24'h123456; man_r = 24'hFEDCBA; man_valid = 1'b1;
            end
        end
        step(1);
        man_valid = 1'b0;
        vectors++;
        if ({new_sample, underrun} !== 2'b10) begin
            miscompares++; $display("FAIL coincident_edge: ns,underrun got %b want 10", {new_sample, underrun});
        end
        wait_frames(9);
        vectors++;
        if (frame_hist[9] !== FRAME_A5) begin
            miscompares++; $display("FAIL coincident_old: got %h want %h", frame_hist[9], FRAME_A5);
        end
        wait_ns("frame10");
        vectors++;
        if (underrun !== 1'b0) begin
            miscompares++; $display("FAIL coincident_fresh: got %b want 0", underrun);
        end
        wait_frames(10);
        vectors++;
        if (frame_hist[10] !== FRAME_X1) begin
            miscompares++; $display("FAIL coincident_new: got %h want %h", frame_hist[10], FRAME_X1);
        end
    endtask

    task automatic test_disable_reset();
        auto_l = 24'hA5A5A5; auto_r = 24'h5A5A5A; auto_en = 1'b1;
        wait_pos(42);
        underrun_clr = 1'b1; step(1); underrun_clr = 1'b0;
        vectors++;
        if ({i2s_lrclk, underrun} !== 2'b10) begin
            miscompares++; $display("FAIL right_slot_pre: lr,underrun got %b want 10", {i2s_lrclk, underrun});
        end
        enable = 1'b0;
        step(1);
        vectors++;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, new_sample} !== 4'b0) begin
            miscompares++;
            $display("FAIL park: bclk,lr,sd,ns got %b want 0000", {i2s_bclk, i2s_lrclk, i2s_sdata, new_sample});
        end
        step(4);
        vectors++;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, underrun} !== 4'b0) begin
            miscompares++;
            $display("FAIL parked_hold: bclk,lr,sd,ur got %b want 0000", {i2s_bclk, i2s_lrclk, i2s_sdata, underrun});
        end
        enable = 1'b1;
        step(16);
        vectors++;
        if (i2s_bclk !== 1'b1) begin
            miscompares++; $display("FAIL reenable_rise: got %b want 1", i2s_bclk);
        end
        step(15);
        vectors++;
        if ({i2s_bclk, new_sample} !== 2'b10) begin
            miscompares++; $display("FAIL reenable_pre_fall: bclk,ns got %b want 10", {i2s_bclk, new_sample});
        end
        step(1);
        vectors++;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, new_sample, underrun} !== 5'b00010) begin
            miscompares++;
            $display("FAIL reenable_fall: bclk,lr,sd,ns,ur got %b want 00010",
                     {i2s_bclk, i2s_lrclk, i2s_sdata, new_sample, underrun});
        end
        wait_pos(40);
        for (int i = 0; i < 40 && i2s_bclk !== 1'b1; i++) step(1);
        vectors++;
        if ({i2s_bclk, i2s_lrclk} !== 2'b11) begin
            miscompares++; $display("FAIL pre_reset_state: bclk,lr got %b want 11", {i2s_bclk, i2s_lrclk});
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({new_sample, i2s_bclk, i2s_lrclk, i2s_sdata, underrun} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %b want 00000",
                     {new_sample, i2s_bclk, i2s_lrclk, i2s_sdata, underrun});
        end
        step(2);
        reset = 1'b0;
        step(32);
        vectors++;
        if ({i2s_bclk, i2s_lrclk, new_sample, underrun} !== 4'b0011) begin
            miscompares++;
            $display("FAIL post_reset_frame: bclk,lr,ns,ur got %b want 0011",
                     {i2s_bclk, i2s_lrclk, new_sample, underrun});
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) frame_hist[i] = '0;
        test_reset();
        test_serial();
        test_period();
        test_underrun();
        test_coincident();
        test_disable_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
